// File: rtl/window_scan_ctrl_pkg.sv
// window_scan_ctrl_pkg: state encoding and width helpers shared by window_scan_ctrl files
package window_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;
   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      FILL = ST_FILL,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
   function automatic int sel_w(input int k);
      return cnt_w(k - 1);
   endfunction
   function automatic int col_w(input int w);
      return cnt_w(w);
   endfunction
   function automatic int row_w(input int h);
      return cnt_w(h);
   endfunction
endpackage

// File: rtl/window_scan_ctrl_if.sv
// window_scan_ctrl_if: pixel/window handshake and line-buffer steering bundle
//   master: pixel source + downstream (drives start_i, valid_i, ready_i)
//   slave : window_scan_ctrl (drives ready_o, lb_wr_*, win_*, col_o, row_o, busy_o, done_o)
interface window_scan_ctrl_if #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 15
);
   logic                                  start_i;
   logic                                  valid_i;
   logic                                  ready_o;
   logic                                  ready_i;
   logic                                  lb_wr_en_o;
   logic [window_pkg::sel_w(K)-1:0]       lb_wr_sel_o;
   logic                                  win_shift_o;
   logic                                  win_valid_o;
   logic [window_pkg::col_w(IMG_W)-1:0]   col_o;
   logic [window_pkg::row_w(IMG_H)-1:0]   row_o;
   logic                                  busy_o;
   logic                                  done_o;
   modport master (
      output start_i, valid_i, ready_i,
      input  ready_o, lb_wr_en_o, lb_wr_sel_o, win_shift_o, win_valid_o,
             col_o, row_o, busy_o, done_o
   );
   modport slave (
      input  start_i, valid_i, ready_i,
      output ready_o, lb_wr_en_o, lb_wr_sel_o, win_shift_o, win_valid_o,
             col_o, row_o, busy_o, done_o
   );
endinterface

// File: rtl/window_scan_ctrl_wrap.sv
// wrap_counter: modulo-N counter with sync clear; wrap flags the enabled step from N-1 to 0
//   clk, rst (async, active-high), en (count), clr (to 0), q (count), wrap (en at N-1)
module wrap_counter import window_pkg::*; #(
   parameter int N = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr,
   output logic [cnt_w(N)-1:0] q,
   output logic                wrap
);
   localparam int W = cnt_w(N);
   assign wrap = en && q == W'(N - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= wrap ? '0 : q + 1'b1;
endmodule

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: raster scan sequencer for a KxK sliding-window front end
//   clk, rst (async, active-high)
//   bus.slave: start_i/valid_i/ready_i in; ready_o, lb_wr_en_o, lb_wr_sel_o,
//              win_shift_o, win_valid_o, col_o, row_o, busy_o, done_o out
module window_scan_ctrl import window_pkg::*; #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 15
) (
   input logic               clk,
   input logic               rst,
   window_scan_ctrl_if.slave bus
);
   localparam int COL_W = col_w(IMG_W);
   localparam int ROW_W = row_w(IMG_H);
   localparam int SEL_W = sel_w(K);
   state_t             state;
   logic               accept;
   logic               clr;
   logic               col_wrap;
   logic               row_wrap;
   logic               sel_wrap;
   logic [COL_W-1:0]   col_q;
   logic [ROW_W-1:0]   row_q;
   logic [SEL_W-1:0]   sel_q;
   assign bus.ready_o     = (state == FILL || state == RUN) && bus.ready_i;
   assign accept          = bus.valid_i && bus.ready_o;
   assign clr             = state == IDLE && bus.start_i;
   assign bus.lb_wr_en_o  = accept;
   assign bus.win_shift_o = accept;
   assign bus.lb_wr_sel_o = sel_q;
   wrap_counter #(.N(IMG_W)) u_col (
      .clk(clk), .rst(rst), .en(accept), .clr(clr), .q(col_q), .wrap(col_wrap)
   );
   wrap_counter #(.N(IMG_H)) u_row (
      .clk(clk), .rst(rst), .en(col_wrap), .clr(clr), .q(row_q), .wrap(row_wrap)
   );
   wrap_counter #(.N(K - 1)) u_sel (
      .clk(clk), .rst(rst), .en(col_wrap), .clr(clr), .q(sel_q), .wrap(sel_wrap)
   );
   // The select counter starts at 0 each frame, so its first wrap is exactly the
   // end of row K-2: the moment the line buffers are full.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state           <= IDLE;
         bus.col_o       <= '0;
         bus.row_o       <= '0;
         bus.win_valid_o <= 1'b0;
         bus.done_o      <= 1'b0;
         bus.busy_o      <= 1'b0;
      end else begin
         bus.win_valid_o <= accept && row_q >= ROW_W'(K - 1) && col_q >= COL_W'(K - 1);
         bus.done_o      <= 1'b0;
         if (accept) begin
            bus.col_o <= col_q;
            bus.row_o <= row_q;
         end
         case (state)
            IDLE: if (bus.start_i) begin
               state      <= FILL;
               bus.busy_o <= 1'b1;
               bus.col_o  <= '0;
               bus.row_o  <= '0;
            end
            FILL: if (sel_wrap) state <= RUN;
            RUN: if (row_wrap) begin
               state      <= DONE;
               bus.done_o <= 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               bus.busy_o <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: directed checks of window_scan_ctrl at 8x6/K=3 and 15x15/K=15
module tb_window_scan_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   window_scan_ctrl_if #(.IMG_W(8), .IMG_H(6), .K(3)) a ();
   window_scan_ctrl_if #(.IMG_W(15), .IMG_H(15), .K(15)) b ();
   window_scan_ctrl #(.IMG_W(8), .IMG_H(6), .K(3)) dut_a (.clk(clk), .rst(rst), .bus(a));
   window_scan_ctrl #(.IMG_W(15), .IMG_H(15), .K(15)) dut_b (.clk(clk), .rst(rst), .bus(b));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic check_zero_a(input string tag);
      check({tag, "_ready"}, a.ready_o, 0);
      check({tag, "_wr_en"}, a.lb_wr_en_o, 0);
      check({tag, "_shift"}, a.win_shift_o, 0);
      check({tag, "_win"}, a.win_valid_o, 0);
      check({tag, "_done"}, a.done_o, 0);
      check({tag, "_busy"}, a.busy_o, 0);
      check({tag, "_col"}, a.col_o, 0);
      check({tag, "_row"}, a.row_o, 0);
      check({tag, "_sel"}, a.lb_wr_sel_o, 0);
   endtask
   task automatic run_a(input bit toggle, input bit poke, input bit abort,
                        output int n_acc, output int n_win, output int n_done);
      int mc, mr, ec, er, cyc;
      bit active, pw, pd, fin, exp_rdy;
      n_acc = 0; n_win = 0; n_done = 0;
      mc = 0; mr = 0; ec = 0; er = 0; cyc = 0;
      pw = 0; pd = 0; fin = 0;
      @(posedge clk); #1 a.start_i = 1'b1;
      @(posedge clk); #1 a.start_i = 1'b0;
      a.valid_i = 1'b1;
      active = 1'b1;
      while (!fin && cyc < 400) begin
         a.ready_i = !(toggle && cyc % 3 == 2);
         a.start_i = poke && cyc == 20;
         @(negedge clk);
         exp_rdy = active && a.ready_i;
         check("ready_o", a.ready_o, exp_rdy);
         check("lb_wr_en", a.lb_wr_en_o, exp_rdy);
         check("win_shift", a.win_shift_o, exp_rdy);
         check("win_valid", a.win_valid_o, pw);
         check("done", a.done_o, pd);
         check("busy", a.busy_o, active || pd);
         check("col_o", a.col_o, ec);
         check("row_o", a.row_o, er);
         if (a.win_valid_o && n_win == 0) begin
            check("first_win_row", a.row_o, 2);
            check("first_win_col", a.col_o, 2);
         end
         if (a.win_valid_o) n_win++;
         if (a.done_o) n_done++;
         fin = pd;
         pw = 0;
         pd = 0;
         if (a.lb_wr_en_o) begin
            if (abort && mr == 3 && mc == 4) begin
               #1 rst = 1'b1;
               #1 check_zero_a("abort");
               fin = 1'b1;
            end else begin
               n_acc++;
               if (mc == 0) check("lb_sel", a.lb_wr_sel_o, mr % 2);
               pw = mr >= 2 && mc >= 2;
               pd = mr == 5 && mc == 7;
               ec = mc;
               er = mr;
               if (pd) active = 1'b0;
               mc = (mc == 7) ? 0 : mc + 1;
               if (mc == 0) mr++;
            end
         end
         @(posedge clk); #1 cyc++;
      end
      a.valid_i = 1'b0;
      a.start_i = 1'b0;
      a.ready_i = 1'b1;
      rst = 1'b0;
      check("frame_end_a", fin, 1);
      check("idle_busy_a", a.busy_o, 0);
   endtask
   task automatic run_b(output int n_win, output int n_done);
      int mc, mr, cyc;
      bit fin;
      n_win = 0; n_done = 0; mc = 0; mr = 0; cyc = 0; fin = 0;
      @(posedge clk); #1 b.start_i = 1'b1;
      @(posedge clk); #1 b.start_i = 1'b0;
      b.valid_i = 1'b1;
      b.ready_i = 1'b1;
      while (!fin && cyc < 400) begin
         @(negedge clk);
         if (b.win_valid_o) begin
            n_win++;
            check("b_win_row", b.row_o, 14);
            check("b_win_col", b.col_o, 14);
            check("b_win_done", b.done_o, 1);
         end
         if (b.done_o) begin
            n_done++;
            fin = 1'b1;
         end
         if (b.lb_wr_en_o) begin
            if (mc == 0 && mr >= 12) check("b_lb_sel", b.lb_wr_sel_o, mr % 14);
            mc = (mc == 14) ? 0 : mc + 1;
            if (mc == 0) mr++;
         end
         @(posedge clk); #1 cyc++;
      end
      b.valid_i = 1'b0;
      check("frame_end_b", fin, 1);
   endtask
   initial begin
      int acc, win, dn;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      a.start_i = 1'b0; a.valid_i = 1'b1; a.ready_i = 1'b1;
      b.start_i = 1'b0; b.valid_i = 1'b0; b.ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_zero_a("reset");
      check("reset_b_busy", b.busy_o, 0);
      rst = 1'b0;
      a.valid_i = 1'b0;
      run_a(1'b0, 1'b0, 1'b0, acc, win, dn);
      check("cont_accepts", acc, 48);
      check("cont_windows", win, 24);
      check("cont_dones", dn, 1);
      run_a(1'b1, 1'b0, 1'b0, acc, win, dn);
      check("stall_accepts", acc, 48);
      check("stall_windows", win, 24);
      check("stall_dones", dn, 1);
      run_a(1'b0, 1'b0, 1'b1, acc, win, dn);
      check("abort_dones", dn, 0);
      check("abort_windows", win, 8);
      run_a(1'b0, 1'b0, 1'b0, acc, win, dn);
      check("restart_windows", win, 24);
      check("restart_dones", dn, 1);
      run_a(1'b0, 1'b1, 1'b0, acc, win, dn);
      check("poke_accepts", acc, 48);
      check("poke_windows", win, 24);
      check("poke_dones", dn, 1);
      run_b(win, dn);
      check("b_windows", win, 1);
      check("b_dones", dn, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
